// File: rtl/crc8_serial_checker_if.sv
// crc8_serial_checker_if: framed serial bit stream in, CRC-8 verdict and status out.
interface crc8_serial_checker_if #(parameter int MAX_BITS = 256);
    localparam int CW = $clog2(MAX_BITS + 1);
    logic          sof;
    logic          en;
    logic          din;
    logic          eof;
    logic          busy;
    logic          done;
    logic          crc_ok;
    logic          crc_err;
    logic          len_err;
    logic          abort;
    logic [7:0]    remainder;
    logic [CW-1:0] bit_cnt;
    modport master (
        output sof, en, din, eof,
        input  busy, done, crc_ok, crc_err, len_err, abort, remainder, bit_cnt
    );
    modport slave (
        input  sof, en, din, eof,
        output busy, done, crc_ok, crc_err, len_err, abort, remainder, bit_cnt
    );
endinterface

// File: rtl/crc8_serial_checker.sv
// crc8_serial_checker: runs the 0x2F CRC-8 LFSR over payload+CRC bits and flags a nonzero remainder.
module crc8_serial_checker #(
    parameter int         MAX_BITS = 256,
    parameter logic [7:0] INIT     = 8'h00
) (
    input logic clk,
    input logic rst,
    crc8_serial_checker_if.slave bus
);
    localparam int CW = $clog2(MAX_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BITS);
    localparam logic [CW-1:0] CNT_MIN = CW'(9);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t        state, state_n;
    logic [7:0]    lfsr, lfsr_n, rem;
    logic [CW-1:0] cnt, cnt_n;
    logic          fin, ovf, clr, abort_n, len_bad;
    logic          done, abort, ok, err, len;

    function automatic logic [7:0] step(input logic [7:0] r, input logic d);
        logic fb;
        fb = r[7] ^ d;
        return {r[6], r[5], r[4] ^ fb, r[3], r[2] ^ fb, r[1] ^ fb, r[0] ^ fb, fb};
    endfunction

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        cnt_n   = cnt;
        fin     = 1'b0;
        ovf     = 1'b0;
        clr     = 1'b0;
        abort_n = 1'b0;
        if (bus.en && bus.sof) begin
            abort_n = state != IDLE;
            lfsr_n  = step(INIT, bus.din);
            cnt_n   = CW'(1);
            fin     = bus.eof;
            clr     = !bus.eof;
            state_n = bus.eof ? IDLE : RECV;
        end else if (bus.en && state == RECV) begin
            lfsr_n  = step(lfsr, bus.din);
            cnt_n   = cnt + 1'b1;
            fin     = bus.eof;
            state_n = bus.eof ? IDLE : (cnt_n == CNT_MAX ? DROP : RECV);
        end else if (bus.en && bus.eof && state == DROP) begin
            fin     = 1'b1;
            ovf     = 1'b1;
            state_n = IDLE;
        end
        len_bad = (cnt_n < CNT_MIN) || ovf;
    end

    // verdict is taken from the post-update count and LFSR so done lands one cycle after eof
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lfsr  <= INIT;
            cnt   <= '0;
            done  <= 1'b0;
            abort <= 1'b0;
            ok    <= 1'b0;
            err   <= 1'b0;
            len   <= 1'b0;
            rem   <= 8'h00;
        end else begin
            state <= state_n;
            lfsr  <= lfsr_n;
            cnt   <= cnt_n;
            done  <= fin;
            abort <= abort_n;
            if (fin) begin
                len <= len_bad;
                ok  <= !len_bad && lfsr_n == 8'h00;
                err <= !len_bad && lfsr_n != 8'h00;
                rem <= lfsr_n;
            end else if (clr) begin
                len <= 1'b0;
                ok  <= 1'b0;
                err <= 1'b0;
            end
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.done      = done;
    assign bus.abort     = abort;
    assign bus.crc_ok    = ok;
    assign bus.crc_err   = err;
    assign bus.len_err   = len;
    assign bus.remainder = rem;
    assign bus.bit_cnt   = cnt;
endmodule

// File: tb/tb_crc8_serial_checker.sv
// tb_crc8_serial_checker: directed and random frames checked against a polynomial-division CRC model.
module tb_crc8_serial_checker;
    localparam int MAXB = 16;
    localparam int CW = $clog2(MAXB + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          passed = 0;
    int          total = 0;
    bit          pend = 1'b0;
    logic [31:0] pv;
    int          pn;
    bit          last_ok, last_err, last_len;

    crc8_serial_checker_if #(.MAX_BITS(MAXB)) bus ();
    crc8_serial_checker #(.MAX_BITS(MAXB), .INIT(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // remainder of the first k bits (MSB-first out of an n-bit value) divided by x^8+0x2F
    function automatic logic [7:0] crc_of(input logic [31:0] v, input int n, input int k);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < k; i++)
            r = {r[6:0], 1'b0} ^ (((r[7] ^ v[n-1-i]) == 1'b1) ? 8'h2F : 8'h00);
        return r;
    endfunction

    task automatic check_verdict(input logic [31:0] v, input int n);
        logic [7:0] r;
        bit         len;
        int         k;
        k = n > MAXB ? MAXB : n;
        r = crc_of(v, n, k);
        len = n < 9 || n > MAXB;
        last_ok = !len && r == 8'h00;
        last_err = !len && r != 8'h00;
        last_len = len;
        chk("done", 32'(bus.done), 1);
        chk("crc_ok", 32'(bus.crc_ok), 32'(last_ok));
        chk("crc_err", 32'(bus.crc_err), 32'(last_err));
        chk("len_err", 32'(bus.len_err), 32'(last_len));
        chk("remainder", 32'(bus.remainder), 32'(r));
        chk("bit_cnt", 32'(bus.bit_cnt), k);
        chk("busy_at_done", 32'(bus.busy), 0);
        chk("abort_at_done", 32'(bus.abort), 0);
    endtask

    task automatic send_frame(input logic [31:0] v, input int n, input bit gap, input bit ab, input bit noeof);
        for (int i = 0; i < n; i++) begin
            if (i > 1 && gap && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                bus.en = 1'b0;
                bus.sof = 1'($urandom);
                bus.eof = 1'($urandom);
                bus.din = 1'($urandom);
            end
            @(negedge clk);
            if (i == 0 && pend) begin
                check_verdict(pv, pn);
                pend = 1'b0;
            end
            if (i > 0) begin
                chk("busy", 32'(bus.busy), 1);
                chk("done_mid", 32'(bus.done), 0);
                chk("bit_cnt_mid", 32'(bus.bit_cnt), i > MAXB ? MAXB : i);
                chk("abort", 32'(bus.abort), 32'(i == 1 && ab));
            end
            bus.en = 1'b1;
            bus.sof = i == 0;
            bus.eof = i == n - 1 && !noeof;
            bus.din = v[n-1-i];
        end
        if (!noeof) begin
            pend = 1'b1;
            pv = v;
            pn = n;
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        bus.en = 1'b0;
        bus.sof = 1'b0;
        bus.eof = 1'b0;
        if (pend) check_verdict(pv, pn);
        pend = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("crc_ok_hold", 32'(bus.crc_ok), 32'(last_ok));
        chk("crc_err_hold", 32'(bus.crc_err), 32'(last_err));
        chk("len_err_hold", 32'(bus.len_err), 32'(last_len));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_crc_ok"}, 32'(bus.crc_ok), 0);
        chk({tag, "_crc_err"}, 32'(bus.crc_err), 0);
        chk({tag, "_len_err"}, 32'(bus.len_err), 0);
        chk({tag, "_abort"}, 32'(bus.abort), 0);
        chk({tag, "_remainder"}, 32'(bus.remainder), 0);
        chk({tag, "_bit_cnt"}, 32'(bus.bit_cnt), 0);
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        bus.en = 1'b0;
        bus.sof = 1'b0;
        bus.eof = 1'b0;
        bus.din = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        send_frame(32'h012F, 16, 0, 0, 0);
        end_frame();
        send_frame(32'h025E, 16, 0, 0, 0);
        end_frame();
        send_frame(32'h025E ^ (32'h1 << $urandom_range(0, 15)), 16, 0, 0, 0);
        end_frame();
        send_frame(32'h0000_0000, 8, 0, 0, 0);
        end_frame();
        send_frame(32'h1, 1, 0, 0, 0);
        end_frame();
        send_frame($urandom & 32'hF_FFFF, 20, 0, 0, 0);
        end_frame();
        send_frame($urandom, 5, 0, 0, 1);
        send_frame(32'h012F, 16, 1, 1, 0);
        end_frame();
        send_frame(32'h025F, 16, 0, 0, 0);
        end_frame();
        send_frame($urandom, 6, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        bus.en = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", 32'(bus.done), 0);
            chk("post_rst_busy", 32'(bus.busy), 0);
        end
        send_frame(32'h012F, 16, 0, 0, 0);
        send_frame(32'h025E, 16, 0, 0, 0);
        end_frame();
        for (int f = 0; f < 60; f++) begin
            n = $urandom_range(1, 20);
            v = $urandom & ((32'h1 << n) - 32'h1);
            if (n >= 9 && n <= MAXB && $urandom_range(0, 1) == 1)
                v = {v[31:8], crc_of(v >> 8, n - 8, n - 8)};
            send_frame(v, n, 1'($urandom), 0, 0);
            if ($urandom_range(0, 1) == 1) end_frame();
        end
        end_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
